// File: rtl/wave_mixer_pkg.sv
// wave_mixer_pkg: shared oscillator settings type, shape encodings and sample width
package wave_mixer_pkg;
  localparam int N_OSCILLATORS = 8;
  localparam int SAMPLE_WIDTH  = 24;
  typedef enum logic [1:0] {SHAPE_SAW, SHAPE_SQUARE, SHAPE_TRI, SHAPE_SILENT} shape_e;
  typedef struct packed {
    logic [31:0] freq;
    logic [7:0]  velocity;
    shape_e      shape;
    logic        enable;
  } wavegen_t;
  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUTPUT} state_e;
endpackage

// File: rtl/wave_mixer_if.sv
// wave_mixer_if: valid/ready sample stream from the mixer to the audio output stage
interface wave_mixer_if;
  import wave_mixer_pkg::*;
  logic signed [SAMPLE_WIDTH-1:0] sample;
  logic                           sample_valid;
  logic                           sample_ready;
  modport master(output sample, output sample_valid, input sample_ready);
  modport slave(input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/wave_shape.sv
// wave_shape: maps a 32-bit phase to a 16-bit signed waveform value
module wave_shape
  import wave_mixer_pkg::*;
(
  input  logic [31:0]        phase,
  input  shape_e             shape,
  output logic signed [15:0] w
);
  assign w = shape == SHAPE_SAW    ? phase[31:16] ^ 16'h8000 :
             shape == SHAPE_SQUARE ? (phase[31] ? 16'sh8000 : 16'sh7fff) :
             shape == SHAPE_TRI    ? (phase[31] ? ~phase[30:15] : phase[30:15]) ^ 16'h8000 :
                                     16'sh0000;
endmodule

// File: rtl/wave_mixer.sv
// wave_mixer: time-multiplexes one shaper/MAC over all oscillators, emitting one
// scaled 24-bit sample per SAMPLE_DIV clocks over a valid/ready stream.
module wave_mixer
  import wave_mixer_pkg::*;
#(
  parameter int N_OSC      = N_OSCILLATORS,
  parameter int SAMPLE_DIV = 2268
) (
  input  logic         clk,
  input  logic         rstn,
  input  wavegen_t     wave_gens [N_OSC],
  input  logic [31:0]  volume,
  wave_mixer_if.master out_if,
  output logic         overrun
);
  localparam int IW = N_OSC > 1 ? $clog2(N_OSC) : 1;
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int AW = SAMPLE_WIDTH + $clog2(N_OSC);
  state_e                         state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic signed [AW-1:0]           acc_q, acc_d, contrib;
  logic [31:0]                    phase_q [N_OSC];
  logic [31:0]                    phase_d [N_OSC];
  logic signed [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic                           valid_q, valid_d, overrun_q, overrun_d;
  logic                           tick, hs, unused_bits;
  wavegen_t                       g;
  logic signed [15:0]             w;
  logic signed [24:0]             prod;
  logic signed [AW+8:0]           scaled;
  assign tick = cnt_q == CW'(SAMPLE_DIV - 1);
  assign hs   = valid_q && out_if.sample_ready;
  assign g    = wave_gens[idx_q];
  wave_shape u_shape (.phase(phase_q[idx_q]), .shape(g.shape), .w(w));
  assign prod        = w * $signed({1'b0, g.velocity});
  assign contrib     = g.enable ? AW'(prod) : '0;
  assign scaled      = (acc_q * $signed({1'b0, volume[7:0]})) >>> (8 + $clog2(N_OSC));
  assign unused_bits = ^{volume[31:8], scaled[AW+8:SAMPLE_WIDTH]};
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    phase_d   = phase_q;
    sample_d  = sample_q;
    overrun_d = overrun_q;
    cnt_d     = tick ? '0 : cnt_q + CW'(1);
    case (state_q)
      IDLE: if (tick) begin
        state_d = ACCUM;
        idx_d   = '0;
        acc_d   = '0;
      end
      ACCUM: begin
        acc_d          = acc_q + contrib;
        phase_d[idx_q] = g.enable ? phase_q[idx_q] + g.freq : '0;
        idx_d          = idx_q + IW'(1);
        if (idx_q == IW'(N_OSC - 1)) state_d = SCALE;
      end
      SCALE: begin
        sample_d = scaled[SAMPLE_WIDTH-1:0];
        state_d  = OUTPUT;
      end
      // a tick that finds the sample unaccepted is dropped and flagged
      default: if (hs) state_d = IDLE; else if (tick) overrun_d = 1'b1;
    endcase
    valid_d = state_d == OUTPUT;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      phase_q   <= '{default: '0};
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      phase_q   <= phase_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  assign out_if.sample       = sample_q;
  assign out_if.sample_valid = valid_q;
  assign overrun             = overrun_q;
endmodule

// File: tb/tb_wave_mixer.sv
// tb_wave_mixer: scoreboard bench; a transaction-level model queues expected samples
// at each tick and a monitor compares them whenever the DUT presents a sample.
module tb_wave_mixer;
  import wave_mixer_pkg::*;
  localparam int N   = 8;
  localparam int DIV = 64;
  localparam int SH  = 8 + $clog2(N);
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  wavegen_t    gens [N];
  logic [31:0] volume;
  logic        overrun;
  wave_mixer_if bus ();
  wave_mixer #(.N_OSC(N), .SAMPLE_DIV(DIV)) dut (
    .clk(clk), .rstn(rstn), .wave_gens(gens), .volume(volume), .out_if(bus), .overrun(overrun)
  );
  always #5 clk = ~clk;
  typedef struct { int smp; int avail; } exp_t;
  exp_t        q[$];
  int unsigned ph [N];
  int          checks = 0, errors = 0, cyc = 0, avail = 0, smp_m;
  bit          ov_m = 0, inflight = 0, out_now, hs_m, exp_valid;
  longint      acc_m;

  task automatic chk(string name, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  function automatic int shape_val(int unsigned p, logic [1:0] s);
    int f;
    case (s)
      2'd0: return int'(p >> 16) - 32768;
      2'd1: return p >= 32'h8000_0000 ? -32768 : 32767;
      2'd2: begin
        f = int'((p >> 15) & 32'hFFFF);
        if (p >= 32'h8000_0000) f = 65535 - f;
        return f - 32768;
      end
      default: return 0;
    endcase
  endfunction

  // reference model: whole sample computed at the tick, delivered N+2 cycles later
  always @(posedge clk) begin
    if (!rstn) begin
      q.delete();
      foreach (ph[i]) ph[i] = 0;
      ov_m = 0;
      inflight = 0;
      cyc = 0;
    end else begin
      out_now = inflight && cyc >= avail;
      hs_m = out_now && bus.sample_ready;
      if (hs_m) inflight = 0;
      if ((cyc % DIV) == DIV - 1) begin
        if (out_now && !hs_m) ov_m = 1;
        else if (!out_now) begin
          acc_m = 0;
          for (int i = 0; i < N; i++) begin
            if (gens[i].enable) begin
              acc_m += longint'(shape_val(ph[i], gens[i].shape)) * longint'(gens[i].velocity);
              ph[i] += gens[i].freq;
            end else ph[i] = 0;
          end
          smp_m = int'((acc_m * longint'(volume[7:0])) >>> SH);
          q.push_back('{smp: smp_m, avail: cyc + N + 2});
          inflight = 1;
          avail = cyc + N + 2;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      exp_valid = q.size() > 0 && cyc >= q[0].avail;
      chk("valid", bus.sample_valid, exp_valid);
      chk("overrun", overrun, ov_m);
      if (exp_valid) begin
        chk("sample", bus.sample, q[0].smp);
        if (bus.sample_ready) void'(q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(int c);
    for (int n = 0; n < 20000 && cyc < c; n++) step();
    chk("goto_reached", cyc >= c, 1);
  endtask

  task automatic clear_gens();
    foreach (gens[i]) gens[i] = '{freq: 32'd0, velocity: 8'd0, shape: SHAPE_SAW, enable: 1'b0};
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) step();
    chk("rst_valid", bus.sample_valid, 0);
    chk("rst_sample", bus.sample, 0);
    chk("rst_overrun", overrun, 0);
    rstn = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clear_gens();
    volume = 0;
    bus.sample_ready = 1'b1;
    do_reset();
    goto(DIV + N + 1);
    chk("first_valid", bus.sample_valid, 1);
    chk("first_sample", bus.sample, 0);
    goto(DIV + 40);
    gens[0] = '{freq: 32'h1000_0000, velocity: 8'd255, shape: SHAPE_SAW, enable: 1'b1};
    volume = 255;
    do_reset();
    goto(DIV + N + 1);
    chk("saw_first", bus.sample, -1040400);
    goto(2 * DIV + N + 1);
    chk("saw_second", bus.sample, -910350);
    goto(2 * DIV + 40);
    bus.sample_ready = 1'b0;
    do_reset();
    goto(3 * DIV + 8);
    chk("held_sample", bus.sample, -1040400);
    chk("held_valid", bus.sample_valid, 1);
    chk("overrun_set", overrun, 1);
    bus.sample_ready = 1'b1;
    goto(4 * DIV + N + 1);
    chk("after_drop", bus.sample, -910350);
    goto(4 * DIV + 32);
    foreach (gens[i]) gens[i] = '{freq: $urandom, velocity: 8'd128, shape: SHAPE_SQUARE, enable: 1'b1};
    volume = 0;
    goto(5 * DIV + N + 1);
    chk("vol_zero", bus.sample, 0);
    goto(7 * DIV + 32);
    volume = 255;
    goto(10 * DIV + 3);
    #1;
    rstn = 1'b0;
    #1;
    chk("async_valid", bus.sample_valid, 0);
    chk("async_sample", bus.sample, 0);
    chk("async_overrun", overrun, 0);
    clear_gens();
    gens[0] = '{freq: 32'h1000_0000, velocity: 8'd200, shape: SHAPE_SAW, enable: 1'b1};
    repeat (2) step();
    rstn = 1'b1;
    goto(DIV + N + 1);
    chk("fresh_sample", bus.sample, -816000);
    goto(DIV + 32);
    gens[0].enable = 1'b0;
    goto(2 * DIV + 32);
    gens[0].enable = 1'b1;
    goto(3 * DIV + N + 1);
    chk("retrigger", bus.sample, -816000);
    for (int k = 0; k < 12 * DIV; k++) begin
      step();
      bus.sample_ready = $urandom_range(0, 3) != 0;
      if ((cyc % DIV) == 32) begin
        foreach (gens[i]) gens[i] = '{freq: $urandom, velocity: 8'($urandom),
                                      shape: shape_e'($urandom_range(0, 3)), enable: 1'($urandom)};
        gens[0].enable = k[6];
        volume = $urandom;
      end
    end
    bus.sample_ready = 1'b1;
    goto(cyc + 2 * DIV);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
